// File: rtl/mpscm_bypass_rf_if.sv
// Bus bundle for mpscm_bypass_rf: write ports, read ports, scrub control and status.
// Latency: none (wires only). Backpressure: none; READY low means the array ignores WE/RE.
// MPSCM_PARITY_EN adds PERR (per read port) and PINJ (per write port).
interface mpscm_bypass_rf_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int WP         = 3,
    parameter int RP         = 5
);
    logic [WP-1:0][DATA_WIDTH-1:0] DIN;
    logic [WP-1:0][ADDR_WIDTH-1:0] WADDR;
    logic [WP-1:0]                 WE;
    logic [RP-1:0][ADDR_WIDTH-1:0] RADDR;
    logic [RP-1:0]                 RE;
    logic [RP-1:0][DATA_WIDTH-1:0] DOUT;
    logic                          SE;
    logic                          CLR;
    logic                          READY;
    logic                          WCONFLICT;
`ifdef MPSCM_PARITY_EN
    logic [RP-1:0]                 PERR;
    logic [WP-1:0]                 PINJ;

    modport master (output DIN, WADDR, WE, RADDR, RE, SE, CLR, PINJ,
                    input  DOUT, READY, WCONFLICT, PERR);
    modport slave  (input  DIN, WADDR, WE, RADDR, RE, SE, CLR, PINJ,
                    output DOUT, READY, WCONFLICT, PERR);
`else
    modport master (output DIN, WADDR, WE, RADDR, RE, SE, CLR,
                    input  DOUT, READY, WCONFLICT);
    modport slave  (input  DIN, WADDR, WE, RADDR, RE, SE, CLR,
                    output DOUT, READY, WCONFLICT);
`endif
endinterface

// File: rtl/mpscm_bypass_rf.sv
// Multi-port register file with registered reads, optional write bypass and zero-fill scrub FSM.
// Latency: reads 1 cycle; writes visible to reads sampled on the next edge.
// Backpressure: none; while READY=0 (scrubbing) WE/RE are ignored. Optional parity: MPSCM_PARITY_EN.
module mpscm_bypass_rf #(
    parameter int ROWS       = 32,
    parameter int ADDR_WIDTH = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int DATA_WIDTH = 32,
    parameter int WP         = 3,
    parameter int RP         = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_ROW   = 1
) (
    input  logic               CLK,
    input  logic               RSTN,
    mpscm_bypass_rf_if.slave   bus
);
    typedef enum logic {ST_SCRUB, ST_RUN} state_t;

    state_t                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]         mem_q [ROWS];
    logic [DATA_WIDTH-1:0]         mem_d [ROWS];
    logic [RP-1:0][DATA_WIDTH-1:0] dout_q, dout_d;
    logic                          wconf_q, wconf_d;
    logic [WP-1:0]                 wr_eff;
`ifdef MPSCM_PARITY_EN
    logic                          par_q [ROWS];
    logic                          par_d [ROWS];
    logic [RP-1:0]                 perr_q, perr_d;
`endif
    logic                          unused_se;

    // Rows that really exist and are writable/readable.
    function automatic logic row_ok(input logic [ADDR_WIDTH-1:0] a);
        return (int'(a) < ROWS) && !((ZERO_ROW != 0) && (a == '0));
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_d   = mem_q;
        dout_d  = dout_q;
        wconf_d = 1'b0;
        wr_eff  = '0;
`ifdef MPSCM_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        if (state_q == ST_SCRUB) begin
            mem_d[ptr_q] = '0;
            dout_d       = '0;
`ifdef MPSCM_PARITY_EN
            par_d[ptr_q] = 1'b0;
            perr_d       = '0;
`endif
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == ADDR_WIDTH'(ROWS - 1)) state_d = ST_RUN;
        end else begin
            for (int j = 0; j < WP; j++) wr_eff[j] = bus.WE[j] && row_ok(bus.WADDR[j]);

            for (int i = 0; i < RP; i++) begin
                if (bus.RE[i]) begin
                    dout_d[i] = '0;
`ifdef MPSCM_PARITY_EN
                    perr_d[i] = 1'b0;
`endif
                    if (row_ok(bus.RADDR[i])) begin
                        dout_d[i] = mem_q[bus.RADDR[i]];
`ifdef MPSCM_PARITY_EN
                        perr_d[i] = (^mem_q[bus.RADDR[i]]) != par_q[bus.RADDR[i]];
`endif
                        // Ascending scan so the highest-index writer is the one bypassed.
                        if (BYPASS != 0) begin
                            for (int j = 0; j < WP; j++) begin
                                if (wr_eff[j] && (bus.WADDR[j] == bus.RADDR[i])) begin
                                    dout_d[i] = bus.DIN[j];
`ifdef MPSCM_PARITY_EN
                                    perr_d[i] = 1'b0;
`endif
                                end
                            end
                        end
                    end
                end
            end

            for (int j = 0; j < WP; j++) begin
                if (wr_eff[j]) begin
                    mem_d[bus.WADDR[j]] = bus.DIN[j];
`ifdef MPSCM_PARITY_EN
                    par_d[bus.WADDR[j]] = (^bus.DIN[j]) ^ bus.PINJ[j];
`endif
                end
            end

            for (int j = 0; j < WP; j++)
                for (int k = j + 1; k < WP; k++)
                    if (wr_eff[j] && wr_eff[k] && (bus.WADDR[j] == bus.WADDR[k])) wconf_d = 1'b1;

            if (bus.CLR) begin
                state_d = ST_SCRUB;
                ptr_d   = '0;
                dout_d  = '0;
`ifdef MPSCM_PARITY_EN
                perr_d  = '0;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= ST_SCRUB;
            ptr_q   <= '0;
            dout_q  <= '0;
            wconf_q <= 1'b0;
`ifdef MPSCM_PARITY_EN
            perr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            wconf_q <= wconf_d;
`ifdef MPSCM_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Array content is deliberately left out of reset; the scrub FSM clears it.
    always_ff @(posedge CLK) begin
        if (RSTN) begin
            mem_q <= mem_d;
`ifdef MPSCM_PARITY_EN
            par_q <= par_d;
`endif
        end
    end

    assign bus.DOUT      = dout_q;
    assign bus.READY     = (state_q == ST_RUN);
    assign bus.WCONFLICT = wconf_q;
`ifdef MPSCM_PARITY_EN
    assign bus.PERR      = perr_q;
`endif
    assign unused_se     = bus.SE;
endmodule

// File: tb/tb_mpscm_bypass_rf.sv
// Directed bench for mpscm_bypass_rf: DUT a (32 rows, bypass) and DUT b (20 rows, no bypass).
module tb_mpscm_bypass_rf;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mpscm_bypass_rf_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WP(3), .RP(5)) ia ();
    mpscm_bypass_rf_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WP(3), .RP(5)) ib ();

    mpscm_bypass_rf #(.ROWS(32), .DATA_WIDTH(32), .WP(3), .RP(5), .BYPASS(1), .ZERO_ROW(1))
        u_a (.CLK(clk), .RSTN(rstn), .bus(ia));
    mpscm_bypass_rf #(.ROWS(20), .DATA_WIDTH(32), .WP(3), .RP(5), .BYPASS(0), .ZERO_ROW(1))
        u_b (.CLK(clk), .RSTN(rstn), .bus(ib));

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] data;
        logic        perr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ia.WE = '0; ia.RE = '0; ia.CLR = 1'b0; ia.SE = 1'b0;
        ib.WE = '0; ib.RE = '0; ib.CLR = 1'b0; ib.SE = 1'b0;
`ifdef MPSCM_PARITY_EN
        ia.PINJ = '0; ib.PINJ = '0;
`endif
    endtask

    task automatic wr(input int dut, input int port, input int addr, input logic [31:0] data,
                      input logic pinj);
        if (dut == 0) begin
            ia.WE[port] = 1'b1; ia.WADDR[port] = 5'(addr); ia.DIN[port] = data;
        end else begin
            ib.WE[port] = 1'b1; ib.WADDR[port] = 5'(addr); ib.DIN[port] = data;
        end
`ifdef MPSCM_PARITY_EN
        if (dut == 0) ia.PINJ[port] = pinj; else ib.PINJ[port] = pinj;
`else
        if (pinj) $display("note: parity injection requested without parity build");
`endif
    endtask

    task automatic rd(input int dut, input int port, input int addr, input logic [31:0] exp,
                      input logic exp_perr);
        exp_t e;
        if (dut == 0) begin
            ia.RE[port] = 1'b1; ia.RADDR[port] = 5'(addr);
        end else begin
            ib.RE[port] = 1'b1; ib.RADDR[port] = 5'(addr);
        end
        e.dut = dut; e.port = port; e.data = exp; e.perr = exp_perr;
        sb.push_back(e);
    endtask

    // One edge, then check every read issued for that edge and clear the inputs.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = (e.dut == 0) ? ia.DOUT[e.port] : ib.DOUT[e.port];
            chk($sformatf("dout d%0d p%0d", e.dut, e.port), obs, e.data);
`ifdef MPSCM_PARITY_EN
            chk($sformatf("perr d%0d p%0d", e.dut, e.port),
                {31'b0, (e.dut == 0) ? ia.PERR[e.port] : ib.PERR[e.port]}, {31'b0, e.perr});
`endif
        end
        idle();
    endtask

    initial begin
        idle();
        ia.WADDR = '0; ia.RADDR = '0; ia.DIN = '0;
        ib.WADDR = '0; ib.RADDR = '0; ib.DIN = '0;

        // Reset held for two edges.
        tick();
        tick();
        chk("rst ready a", {31'b0, ia.READY}, 32'd0);
        chk("rst ready b", {31'b0, ib.READY}, 32'd0);
        chk("rst wconf a", {31'b0, ia.WCONFLICT}, 32'd0);
        chk("rst dout a", {31'b0, |ia.DOUT}, 32'd0);
        chk("rst dout b", {31'b0, |ib.DOUT}, 32'd0);
        rstn = 1'b1;

        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("scrub0 ready a k%0d", k), {31'b0, ia.READY}, {31'b0, k == 32});
            if (k == 19 || k == 20)
                chk($sformatf("scrub0 ready b k%0d", k), {31'b0, ib.READY}, {31'b0, k == 20});
        end

        for (int p = 0; p < 5; p++) rd(0, p, 5, 32'h0, 1'b0);
        tick();

        // Basic write then read, and row 0 forced to zero.
        wr(0, 0, 7, 32'hDEADBEEF, 1'b0);
        tick();
        rd(0, 1, 7, 32'hDEADBEEF, 1'b0);
        tick();
        tick();
        chk("dout hold p1", ia.DOUT[1], 32'hDEADBEEF);
        wr(0, 0, 0, 32'h1, 1'b0);
        tick();
        rd(0, 2, 0, 32'h0, 1'b0);
        tick();

        // Write conflict: highest port wins, flag for one cycle.
        wr(0, 0, 9, 32'h11, 1'b0);
        wr(0, 2, 9, 32'h22, 1'b0);
        tick();
        chk("wconf set", {31'b0, ia.WCONFLICT}, 32'd1);
        rd(0, 3, 9, 32'h22, 1'b0);
        tick();
        chk("wconf clear", {31'b0, ia.WCONFLICT}, 32'd0);
        wr(0, 0, 10, 32'h10, 1'b0);
        wr(0, 1, 11, 32'h11, 1'b0);
        tick();
        chk("wconf distinct rows", {31'b0, ia.WCONFLICT}, 32'd0);

        // Bypass on a, pre-write content on b.
        wr(0, 0, 3, 32'hA, 1'b0);
        wr(1, 0, 3, 32'hA, 1'b0);
        tick();
        wr(0, 1, 3, 32'hB, 1'b0);
        rd(0, 0, 3, 32'hB, 1'b0);
        wr(1, 1, 3, 32'hB, 1'b0);
        rd(1, 0, 3, 32'hA, 1'b0);
        tick();
        rd(1, 0, 3, 32'hB, 1'b0);
        tick();

        // Out-of-range rows on the 20-row instance.
        wr(1, 0, 25, 32'h77, 1'b0);
        tick();
        rd(1, 1, 25, 32'h0, 1'b0);
        rd(1, 2, 5, 32'h0, 1'b0);
        tick();

`ifdef MPSCM_PARITY_EN
        wr(0, 0, 4, 32'h5, 1'b1);
        tick();
        rd(0, 0, 4, 32'h5, 1'b1);
        tick();
        wr(0, 0, 4, 32'h5, 1'b0);
        tick();
        rd(0, 0, 4, 32'h5, 1'b0);
        tick();
        wr(0, 0, 6, 32'h7, 1'b1);
        rd(0, 1, 6, 32'h7, 1'b0);
        tick();
`endif

        // Scrub on request; CLR and writes during scrub are ignored.
        ia.CLR = 1'b1;
        tick();
        chk("clr ready low", {31'b0, ia.READY}, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            if (k == 2) begin
                wr(0, 0, 30, 32'h1, 1'b0);
                wr(0, 1, 30, 32'h2, 1'b0);
            end
            if (k == 3) rd(0, 1, 7, 32'h0, 1'b0);
            if (k == 10) ia.CLR = 1'b1;
            if (k == 25) wr(0, 0, 5, 32'h99, 1'b0);
            tick();
            if (k == 2) chk("scrub wconf", {31'b0, ia.WCONFLICT}, 32'd0);
            chk($sformatf("scrub1 ready k%0d", k), {31'b0, ia.READY}, {31'b0, k == 32});
        end
        for (int r = 0; r < 32; r++) begin
            rd(0, r % 5, r, 32'h0, 1'b0);
            if (r % 5 == 4 || r == 31) tick();
        end

        // Reset in the middle of a scrub restarts it from row 0.
        ia.CLR = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("scrub2 ready k%0d", k), {31'b0, ia.READY}, {31'b0, k == 32});
        end
        wr(0, 2, 12, 32'h12345678, 1'b0);
        tick();
        rd(0, 4, 12, 32'h12345678, 1'b0);
        tick();

        if (sb.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: observed=%0d expected=0 pending", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
